// File: rtl/da_input_slicer_pkg.sv
// Shared constants and types for the DA FIR input slicer.
package da_input_slicer_pkg;
  localparam int NTAPS = 64;
  localparam int NBANK = 8;
  localparam int ACC_W = 39;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ISSUE, S_WAIT, S_SETTLE, S_OUT
  } state_e;

  // plane[bank][bit] = bit k of tap (bank*NBANK + bit)
  typedef logic [NBANK-1:0][NBANK-1:0] plane_t;
endpackage

// File: rtl/da_input_slicer_tap_line.sv
// 64-tap sample delay line stored in offset binary, with a bit-plane selector.
module da_input_slicer_tap_line
  import da_input_slicer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KW     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [KW-1:0]     k,
  output plane_t            plane
);
  logic [NTAPS-1:0][DATA_W-1:0] taps;

  // MSB inversion turns two's complement into offset binary, so every plane adds with +2^k
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       taps <= '0;
    else if (shift_en) taps <= {taps[NTAPS-2:0], {~sample_in[DATA_W-1], sample_in[DATA_W-2:0]}};
  end

  for (genvar n = 0; n < NTAPS; n++) begin : g_tap
    assign plane[n/NBANK][n%NBANK] = taps[n][k];
  end
endmodule

// File: rtl/da_input_slicer.sv
// Feeds the DA FIR core: one sample in, DATA_W bit-planes issued MSB first, one output out.
module da_input_slicer
  import da_input_slicer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              cload_busy,
  input  logic [ACC_W-1:0]  ofs_corr,
  output logic [7:0]        A7,
  output logic [7:0]        A6,
  output logic [7:0]        A5,
  output logic [7:0]        A4,
  output logic [7:0]        A3,
  output logic [7:0]        A2,
  output logic [7:0]        A1,
  output logic [7:0]        A0,
  output logic              da_start,
  output logic              da_acc_clr,
  input  logic              da_done,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  output logic              timeout_err
);
  localparam int KW = $clog2(DATA_W);
  localparam int WW = $clog2(DONE_TIMEOUT + 1);

  state_e        state;
  logic [KW-1:0] k;
  logic [WW-1:0] wdog;
  plane_t        plane, a_q;
  logic          rdy_en;
  logic          accept;

  // rdy_en keeps sample_ready low while resetn is asserted
  assign sample_ready = rdy_en && (state == S_IDLE) && !cload_busy;
  assign accept       = sample_valid && sample_ready;

  da_input_slicer_tap_line #(.DATA_W(DATA_W), .KW(KW)) u_tap_line (
    .clk       (clk),
    .resetn    (resetn),
    .shift_en  (accept),
    .sample_in (sample_in),
    .k         (k),
    .plane     (plane)
  );

  assign {A7, A6, A5, A4, A3, A2, A1, A0} = a_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      k           <= '0;
      wdog        <= '0;
      a_q         <= '0;
      da_start    <= 1'b0;
      da_acc_clr  <= 1'b0;
      y_out       <= '0;
      y_valid     <= 1'b0;
      timeout_err <= 1'b0;
      rdy_en      <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      da_start   <= 1'b0;
      da_acc_clr <= 1'b0;
      y_valid    <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          k     <= KW'(DATA_W - 1);
          state <= S_CLR;
        end
        S_CLR: begin
          da_acc_clr <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          a_q      <= plane;
          da_start <= 1'b1;
          wdog     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a simultaneous watchdog expiry
          if (da_done) begin
            if (k == '0) state <= S_SETTLE;
            else begin
              k     <= k - KW'(1);
              state <= S_ISSUE;
            end
          end else if (wdog == WW'(DONE_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        // the core's ACC register updates the cycle after done
        S_SETTLE: state <= S_OUT;
        S_OUT: begin
          y_out   <= acc_in - ofs_corr;
          y_valid <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
